// File: rtl/button_encoder_pkg.sv
// Shared definitions for the button encoder: colour codes, FSM states,
// button count and small helpers on the debounced button vector.
package button_pkg;

  localparam int NUM_BUTTONS = 4;

  // Colour codes presented on IN; colour k is BTN[k].
  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] GREEN  = 2'd1;
  localparam logic [1:0] BLUE   = 2'd2;
  localparam logic [1:0] YELLOW = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HELD    = 2'd1,
    LOCKOUT = 2'd2
  } state_e;

  // True when exactly one button is pressed.
  function automatic logic is_onehot(input logic [NUM_BUTTONS-1:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Colour code of a one-hot button vector; RED for anything else.
  function automatic logic [1:0] encode_btn(input logic [NUM_BUTTONS-1:0] v);
    logic [1:0] code;
    case (v)
      4'b0001: code = RED;
      4'b0010: code = GREEN;
      4'b0100: code = BLUE;
      4'b1000: code = YELLOW;
      default: code = RED;
    endcase
    return code;
  endfunction

  // Button mask belonging to a colour code.
  function automatic logic [NUM_BUTTONS-1:0] code_mask(input logic [1:0] code);
    return 4'b0001 << code;
  endfunction

endpackage

// File: rtl/button_encoder_if.sv
// Player-input bus between the board buttons / controller and the encoder.
// master: the side driving buttons and ENABLE (controller/board).
// slave : the encoder itself.
interface button_encoder_if;
  import button_pkg::*;

  logic [NUM_BUTTONS-1:0] BTN;
  logic                   ENABLE;
  logic [1:0]             IN;
  logic                   IN_VALID;
  logic                   ANY_PRESSED;

  modport master (
    output BTN,
    output ENABLE,
    input  IN,
    input  IN_VALID,
    input  ANY_PRESSED
  );

  modport slave (
    input  BTN,
    input  ENABLE,
    output IN,
    output IN_VALID,
    output ANY_PRESSED
  );
endinterface

// File: rtl/button_encoder_btn_debounce.sv
// Single-button synchroniser and debouncer. The raw input only ever feeds
// the first synchroniser flop; the stable level flips after the synchronised
// level has differed from it for DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic STABLE_RST      = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic stable_o
);

  localparam int              CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic                   stable_q;
  logic                   stable_d;
  logic                   sync_level_s;

  assign sync_level_s = sync_q[SYNC_STAGES-1];

  // Synchroniser shift chain, raw button enters at bit 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
    end
  end

  // Debounce counter: counts while levels differ, flips stable at the limit.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync_level_s != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = ~stable_q;
        cnt_d    = '0;
      end else begin
        cnt_d    = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Debounce state registers; stable level resets to its configured value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      stable_q <= STABLE_RST;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/button_encoder.sv
// Player-input front end: four debounced buttons, chord rejection and a
// one-cycle IN_VALID strobe with the encoded colour per accepted press.
// Build option: define RELEASE_COMMIT_EN to emit the event when the button
// is released instead of when it is pressed.
// Debounced levels reset to "pressed" and the FSM to LOCKOUT, so a button
// held across reset release must be released before it can produce an event.
module button_encoder
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic             CLK,
  input  logic             RST,
  button_encoder_if.slave  bus
);

  logic [NUM_BUTTONS-1:0] d_s;
  logic [NUM_BUTTONS-1:0] held_mask_s;
  logic                   d_onehot_s;

  state_e     state_q;
  state_e     state_d;
  logic [1:0] code_q;
  logic [1:0] code_d;
  logic [1:0] in_q;
  logic [1:0] in_d;
  logic       in_valid_q;
  logic       in_valid_d;
  logic       any_q;

  for (genvar k = 0; k < NUM_BUTTONS; k++) begin : g_btn
    btn_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .STABLE_RST      (1'b1)
    ) u_debounce (
      .clk_i    (CLK),
      .rst_i    (RST),
      .btn_i    (bus.BTN[k]),
      .stable_o (d_s[k])
    );
  end

  assign d_onehot_s  = is_onehot(d_s);
  assign held_mask_s = code_mask(code_q);

  // Next-state, latched code and event strobe decisions.
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    in_d       = in_q;
    in_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_s == 4'd0) begin
          state_d = IDLE;
        end else if (d_onehot_s) begin
          state_d = HELD;
          code_d  = encode_btn(d_s);
`ifndef RELEASE_COMMIT_EN
          if (bus.ENABLE) begin
            in_valid_d = 1'b1;
            in_d       = encode_btn(d_s);
          end else begin
            in_valid_d = 1'b0;
          end
`endif
        end else begin
          // Simultaneous presses are a chord: no event.
          state_d = LOCKOUT;
        end
      end
      HELD: begin
        if ((d_s & ~held_mask_s) != 4'd0) begin
          // Another button joined: chord, any pending event is dropped.
          state_d = LOCKOUT;
        end else if (d_s == 4'd0) begin
          state_d = IDLE;
`ifdef RELEASE_COMMIT_EN
          if (bus.ENABLE) begin
            in_valid_d = 1'b1;
            in_d       = code_q;
          end else begin
            in_valid_d = 1'b0;
          end
`endif
        end else begin
          state_d = HELD;
        end
      end
      LOCKOUT: begin
        if (d_s == 4'd0) begin
          state_d = IDLE;
        end else begin
          state_d = LOCKOUT;
        end
      end
      default: begin
        state_d = LOCKOUT;
      end
    endcase
  end

  // FSM and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= LOCKOUT;
      code_q     <= RED;
      in_q       <= 2'd0;
      in_valid_q <= 1'b0;
      any_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      in_q       <= in_d;
      in_valid_q <= in_valid_d;
      any_q      <= |d_s;
    end
  end

  assign bus.IN          = in_q;
  assign bus.IN_VALID    = in_valid_q;
  assign bus.ANY_PRESSED = any_q;

endmodule

// File: tb/tb_button_encoder.sv
// Directed bench for button_encoder with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Expected events are queued with their due cycle when a button edge is
// driven; every IN_VALID pulse is matched against the queue head.
module tb_button_encoder;

  localparam int DC  = 4;
  localparam int SS  = 2;
  localparam int LAT = SS + DC + 1;
`ifdef RELEASE_COMMIT_EN
  localparam bit REL_MODE = 1'b1;
`else
  localparam bit REL_MODE = 1'b0;
`endif

  typedef struct {
    logic [1:0] code;
    int         cyc;
  } evt_t;

  logic CLK;
  logic RST;
  int   cyc;
  int   n_chk;
  int   n_fail;
  evt_t exp_q[$];

  button_encoder_if bus ();

  button_encoder #(
    .DEBOUNCE_CYCLES (DC),
    .SYNC_STAGES     (SS)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Queue an event due LAT cycles from now if it belongs to this build's mode.
  task automatic push_evt(input logic [1:0] code, input bit on_release);
    evt_t e;
    if (on_release == REL_MODE) begin
      e.code = code;
      e.cyc  = cyc + LAT;
      exp_q.push_back(e);
    end
  endtask

  // Advance n clocks, sampling 1 time unit after each rising edge.
  task automatic tick(input int n);
    evt_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      cyc++;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        chk("missed_event_cycle", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (bus.IN_VALID === 1'b1) begin
        chk("valid_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("event_cycle", cyc, e.cyc);
          chk("event_code", bus.IN, e.code);
        end
      end
    end
  endtask

  initial begin
    cyc        = 0;
    n_chk      = 0;
    n_fail     = 0;
    RST        = 1'b1;
    bus.BTN    = 4'b0000;
    bus.ENABLE = 1'b1;

    // Reset values
    tick(3);
    chk("rst_in", bus.IN, 2'd0);
    chk("rst_valid", bus.IN_VALID, 1'b0);
    chk("rst_any", bus.ANY_PRESSED, 1'b1);
    RST = 1'b0;
    tick(10);
    chk("settle_any", bus.ANY_PRESSED, 1'b0);

    // Clean single press of BLUE
    bus.BTN = 4'b0100;
    push_evt(2'd2, 1'b0);
    tick(20);
    chk("blue_any", bus.ANY_PRESSED, 1'b1);
    bus.BTN = 4'b0000;
    push_evt(2'd2, 1'b1);
    tick(12);
    chk("blue_in", bus.IN, 2'd2);
    chk("blue_rel_any", bus.ANY_PRESSED, 1'b0);

    // Short glitches on GREEN must be filtered
    for (int i = 0; i < 8; i++) begin
      bus.BTN = 4'b0010;
      tick(i % 3 + 1);
      bus.BTN = 4'b0000;
      tick(2);
      chk("glitch_any", bus.ANY_PRESSED, 1'b0);
    end
    tick(8);
    chk("glitch_in", bus.IN, 2'd2);

    // Simultaneous chord RED+YELLOW, then a clean YELLOW
    bus.BTN = 4'b1001;
    tick(20);
    chk("chord_any", bus.ANY_PRESSED, 1'b1);
    bus.BTN = 4'b0000;
    tick(10);
    chk("chord_rel_any", bus.ANY_PRESSED, 1'b0);
    bus.BTN = 4'b1000;
    push_evt(2'd3, 1'b0);
    tick(20);
    bus.BTN = 4'b0000;
    push_evt(2'd3, 1'b1);
    tick(12);
    chk("yellow_in", bus.IN, 2'd3);

    // Reset asserted mid-press, button held through reset release
    bus.BTN = 4'b0001;
    push_evt(2'd0, 1'b0);
    tick(10);
    RST = 1'b1;
    #1;
    chk("midrst_in", bus.IN, 2'd0);
    chk("midrst_valid", bus.IN_VALID, 1'b0);
    chk("midrst_any", bus.ANY_PRESSED, 1'b1);
    tick(3);
    RST = 1'b0;
    tick(10);
    chk("held_through_rst_any", bus.ANY_PRESSED, 1'b1);
    bus.BTN = 4'b0000;
    tick(10);
    chk("held_rel_any", bus.ANY_PRESSED, 1'b0);
    bus.BTN = 4'b0001;
    push_evt(2'd0, 1'b0);
    tick(12);
    bus.BTN = 4'b0000;
    push_evt(2'd0, 1'b1);
    tick(12);
    chk("red_in", bus.IN, 2'd0);

    // ENABLE low at press time discards the press event
    bus.ENABLE = 1'b0;
    bus.BTN    = 4'b1000;
    tick(10);
    bus.ENABLE = 1'b1;
    tick(10);
    bus.BTN = 4'b0000;
    push_evt(2'd3, 1'b1);
    tick(12);
    bus.BTN = 4'b1000;
    push_evt(2'd3, 1'b0);
    tick(12);
    bus.BTN = 4'b0000;
    push_evt(2'd3, 1'b1);
    tick(12);
    chk("enable_in", bus.IN, 2'd3);

    // BLUE held, RED joins, both released: chord cancels any release event
    bus.BTN = 4'b0100;
    push_evt(2'd2, 1'b0);
    tick(10);
    bus.BTN = 4'b0101;
    tick(10);
    bus.BTN = 4'b0000;
    tick(12);
    chk("late_chord_any", bus.ANY_PRESSED, 1'b0);

    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
